// File: rtl/rf_pkg.sv
// Shared types for the register-file port arbiter: FSM encoding and client ids.
package rf_pkg;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic C0 = 1'b0;
  localparam logic C1 = 1'b1;
endpackage

// File: rtl/rr_sel2.sv
// Two-way round-robin select: a lone requester wins, a tie goes to the pointer holder.
module rr_sel2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/rf_arbiter.sv
// Serialises two clients onto one register-file port: one accepted request,
// then one ACCESS cycle in which the held request drives the register file.
module rf_arbiter
  import rf_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0_valid,
  input  logic          c0_we,
  input  logic [AW-1:0] c0_addr,
  input  logic [DW-1:0] c0_wdata,
  output logic          c0_ready,
  output logic          c0_rvalid,
  output logic [DW-1:0] c0_rdata,
  input  logic          c1_valid,
  input  logic          c1_we,
  input  logic [AW-1:0] c1_addr,
  input  logic [DW-1:0] c1_wdata,
  output logic          c1_ready,
  output logic          c1_rvalid,
  output logic [DW-1:0] c1_rdata,
  output logic [AW-1:0] rf_ra0,
  input  logic [DW-1:0] rf_rd0,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          rf_we
);
  state_t        state, state_nxt;
  logic          ptr, hid, hwe;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic [1:0]    req, gnt, rdy, rvalid;
  logic          acc, acc_id;

  assign req = {c1_valid, c0_valid};

  rr_sel2 u_sel (.req(req), .ptr(ptr), .gnt(gnt));

  always_comb begin
    state_nxt = state;
    rdy       = 2'b00;
    case (state)
      IDLE: begin
        rdy = gnt;
        if (|gnt) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign acc    = |(rdy & req);
  assign acc_id = rdy[1] ? C1 : C0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= C0;
      hid      <= C0;
      hwe      <= 1'b0;
      haddr    <= '0;
      hwdata   <= '0;
      rvalid   <= 2'b00;
      c0_rdata <= '0;
      c1_rdata <= '0;
    end else begin
      state  <= state_nxt;
      rvalid <= 2'b00;
      if (acc) begin
        ptr    <= ~acc_id;
        hid    <= acc_id;
        hwe    <= acc_id ? c1_we    : c0_we;
        haddr  <= acc_id ? c1_addr  : c0_addr;
        hwdata <= acc_id ? c1_wdata : c0_wdata;
      end
      if (state == ACCESS && !hwe) begin
        rvalid[hid] <= 1'b1;
        if (hid == C1) c1_rdata <= rf_rd0;
        else           c0_rdata <= rf_rd0;
      end
    end
  end

  assign c0_ready  = rdy[0];
  assign c1_ready  = rdy[1];
  assign c0_rvalid = rvalid[0];
  assign c1_rvalid = rvalid[1];

  // Holding registers only move on acceptance, so the RF address/data stay quiet in IDLE.
  assign rf_ra0 = haddr;
  assign rf_wa  = haddr;
  assign rf_wd  = hwdata;
  // Gated by rst so a reset landing in ACCESS kills the write on that same edge.
  assign rf_we  = rst && (state == ACCESS) && hwe && (haddr != '0);
endmodule

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, meaning register data width.
REQ-002 SHALL have parameter AW, default 5, meaning register address width (32 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports c0_valid / c1_valid  input  1 each  client request valid.
REQ-006 SHALL have ports c0_we / c1_we  input  1 each  1 = write request, 0 = read request.
REQ-007 SHALL have ports c0_addr / c1_addr  input  AW each  register address.
REQ-008 SHALL have ports c0_wdata / c1_wdata  input  DW each  write data.
REQ-009 SHALL have ports c0_ready / c1_ready  output  1 each  request accepted this cycle.
REQ-010 SHALL have ports c0_rvalid / c1_rvalid  output  1 each  one-cycle read-data-valid pulse.
REQ-011 SHALL have ports c0_rdata / c1_rdata  output  DW each  read data, held until the next read response to that client.
REQ-012 SHALL have ports rf_ra0  output  AW, rf_rd0  input  DW, rf_wa  output  AW, rf_wd  output  DW, rf_we  output  1, connecting to the register file (combinational read, clocked write).

Function
REQ-013 SHALL implement FSM states IDLE and ACCESS; IDLE -> ACCESS on acceptance; ACCESS -> IDLE unconditionally after one cycle; the result is at most one accepted request per 2 cycles.
REQ-014 In IDLE, SHALL assert cX_ready combinationally for exactly one valid client: the sole valid client, or the round-robin priority holder when both are valid; ready SHALL be 0 in ACCESS.
REQ-015 Acceptance SHALL occur when cX_valid and cX_ready are both 1; the arbiter SHALL latch client id, we, addr and wdata into holding registers on that edge.
REQ-016 The round-robin pointer SHALL flip to the non-granted client after each acceptance and SHALL be unchanged when nothing is accepted.
REQ-017 In ACCESS, SHALL drive rf_ra0/rf_wa = held addr and rf_wd = held wdata; rf_we = 1 only for a held write with addr != 0.
REQ-018 A write to address 0 SHALL be accepted (ready handshake completes) and silently discarded: rf_we stays 0.
REQ-019 In ACCESS for a held read, SHALL capture rf_rd0 into the owning client's rdata register and pulse that client's rvalid for exactly the cycle after ACCESS; the other client's rvalid/rdata SHALL be unchanged.
REQ-020 Writes SHALL produce no rvalid pulse.
REQ-021 Outside ACCESS, rf_we SHALL be 0; rf_ra0, rf_wa and rf_wd SHALL hold their last values (no toggling).
REQ-022 A read issued after a write to the same address SHALL return the new data (guaranteed by serialisation; no bypass).
REQ-023 cX_valid deasserted before acceptance SHALL withdraw the request with no side effect.

Reset
REQ-024 When rst = 0 at a rising edge, SHALL set: state = IDLE, pointer = client 0, holding registers = 0, rf_we = 0, rvalid = 0 and rdata = 0 for both clients.
REQ-025 Reset during ACCESS SHALL abort the operation: rf_we = 0 that cycle, no rvalid pulse, and no register-file write.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE, ACCESS) and the client-id constants (C0 = 0, C1 = 1) in the shared package rf_pkg.
REQ-027 SHALL be a single module; round-robin selection MAY be factored into the sub-module rr_sel2 (2-way round-robin arbiter).

Verification
REQ-028 After reset, c0 writes 0x1234_5678 to r3, then c0 reads r3 -> c0_rvalid pulses once with c0_rdata = 0x1234_5678.
REQ-029 c0 and c1 valid continuously after reset -> grant order c0, c1, c0, c1, with acceptances 2 cycles apart.
REQ-030 c1 writes 0xDEAD_BEEF to r0 -> c1_ready pulses, rf_we stays 0; a following read of r0 -> 0x0000_0000.
REQ-031 c0 reads r5 while c1 is idle -> only c0_rvalid pulses and c1_rdata is unchanged.
REQ-032 Reset asserted in the ACCESS cycle of a write of 0xFFFF_FFFF to r7 -> no rf_we, no rvalid, state IDLE, pointer = c0.
